// File: rtl/eth_phy_10g_pkg.sv
// eth_phy_10g_pkg
// Shared definitions for the 10GBASE-R RX link bring-up sequencer.
//   link_state_e : state encoding, also observed by status/CSR logic
//   ERR_CNT_W    : width of the PHY per-cycle error count
//   LOSS_CNT_W   : width of the lock-loss counter
package eth_phy_10g_pkg;

    localparam int ERR_CNT_W  = 7;
    localparam int LOSS_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SERDES_RST  = 3'd1,
        ST_WAIT_LOCK   = 3'd2,
        ST_WAIT_STABLE = 3'd3,
        ST_LINK_UP     = 3'd4,
        ST_PRBS_TEST   = 3'd5,
        ST_FAIL        = 3'd6
    } link_state_e;

endpackage

// File: rtl/eth_phy_10g_sat_accum.sv
// eth_phy_10g_sat_accum
// Registered saturating accumulator. The sum sticks at all-ones instead of
// wrapping.
//   clk, rst_n : clock, asynchronous active-low reset (sum -> 0)
//   clr        : synchronous clear, has priority over en
//   en         : add 'add' this cycle
//   add        : zero-extended addend (IN_W <= W)
//   sum        : registered accumulated value
module eth_phy_10g_sat_accum
    import eth_phy_10g_pkg::*;
#(
    parameter int W    = 16,
    parameter int IN_W = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [IN_W-1:0] add,
    output logic [W-1:0]    sum
);

    logic [W-1:0] sum_r;

    // One extra bit catches the carry out; a carry means clamp to all-ones.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                             input logic [IN_W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + (W+1)'(b);
        if (s[W]) begin
            sat_add = {W{1'b1}};
        end else begin
            sat_add = s[W-1:0];
        end
    endfunction

    // Accumulator register: clear, add-with-saturation, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= {W{1'b0}};
        end else if (clr) begin
            sum_r <= {W{1'b0}};
        end else if (en) begin
            sum_r <= sat_add(sum_r, add);
        end else begin
            sum_r <= sum_r;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/eth_phy_10g_link_seq.sv
// eth_phy_10g_link_seq
// Link bring-up sequencer for the 10GBASE-R PHY RX path (rx_clk domain).
// Pulses the SERDES RX reset, waits for block lock with timeout/retry,
// qualifies a stable lock/BER window before declaring link up, and runs a
// PRBS31 test session on request while accumulating PHY errors.
//   Inputs : rx_clk, rx_rst_n, cfg_enable, cfg_prbs_req, rx_block_lock,
//            rx_high_ber, rx_status, rx_error_count[6:0]
//   Outputs: serdes_rx_reset_req, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
//            link_up, link_fail, link_state[2:0], retry_count[3:0],
//            lock_loss_count[15:0], prbs_err_total[PRBS_ERR_WIDTH-1:0]
// All outputs are registered and change together with the state register.
module eth_phy_10g_link_seq
    import eth_phy_10g_pkg::*;
#(
    parameter int SERDES_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT      = 4096,
    parameter int STABLE_CYCLES     = 1024,
    parameter int MAX_RETRIES       = 7,
    parameter int PRBS_ERR_WIDTH    = 16
) (
    input  logic                      rx_clk,
    input  logic                      rx_rst_n,
    input  logic                      cfg_enable,
    input  logic                      cfg_prbs_req,
    input  logic                      rx_block_lock,
    input  logic                      rx_high_ber,
    input  logic                      rx_status,
    input  logic [ERR_CNT_W-1:0]      rx_error_count,
    output logic                      serdes_rx_reset_req,
    output logic                      cfg_tx_prbs31_enable,
    output logic                      cfg_rx_prbs31_enable,
    output logic                      link_up,
    output logic                      link_fail,
    output logic [2:0]                link_state,
    output logic [3:0]                retry_count,
    output logic [LOSS_CNT_W-1:0]     lock_loss_count,
    output logic [PRBS_ERR_WIDTH-1:0] prbs_err_total
);

    // The shared timer also paces the SERDES reset pulse, so it must hold
    // SERDES_RST_CYCLES-1 as well as the lock/stable windows.
    localparam int MAX_WIN = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int CNT_MAX = (MAX_WIN > SERDES_RST_CYCLES) ? MAX_WIN : SERDES_RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(SERDES_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_DONE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    link_state_e       state_r, next_state_s;
    logic [CNT_W-1:0]  timer_r, timer_nxt_s;
    logic [CNT_W-1:0]  stable_r, stable_nxt_s;
    logic [CNT_W-1:0]  timer_inc_s, stable_inc_s;
    logic [3:0]        retry_r, retry_nxt_s, retry_inc_s;
    logic              loss_inc_s;
    logic              prbs_clr_s;
    logic              prbs_acc_en_s;
    logic              serdes_req_r, tx_prbs_r, rx_prbs_r, link_up_r, link_fail_r;

    assign timer_inc_s   = timer_r + CNT_ONE;
    assign stable_inc_s  = stable_r + CNT_ONE;
    assign retry_inc_s   = retry_r + 4'd1;
    assign prbs_acc_en_s = (state_r == ST_PRBS_TEST);

    // State, timer, stable-window and retry registers.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_r  <= ST_IDLE;
            timer_r  <= CNT_ZERO;
            stable_r <= CNT_ZERO;
            retry_r  <= 4'd0;
        end else begin
            state_r  <= next_state_s;
            timer_r  <= timer_nxt_s;
            stable_r <= stable_nxt_s;
            retry_r  <= retry_nxt_s;
        end
    end

    // Next-state logic; cfg_enable low overrides every state.
    always_comb begin
        next_state_s = state_r;
        timer_nxt_s  = timer_r;
        stable_nxt_s = stable_r;
        retry_nxt_s  = retry_r;
        loss_inc_s   = 1'b0;
        prbs_clr_s   = 1'b0;
        if (!cfg_enable) begin
            next_state_s = ST_IDLE;
            timer_nxt_s  = CNT_ZERO;
            stable_nxt_s = CNT_ZERO;
            retry_nxt_s  = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    next_state_s = ST_SERDES_RST;
                    timer_nxt_s  = CNT_ZERO;
                end
                ST_SERDES_RST: begin
                    if (timer_r == RST_LAST) begin
                        next_state_s = ST_WAIT_LOCK;
                        timer_nxt_s  = CNT_ZERO;
                    end else begin
                        timer_nxt_s  = timer_inc_s;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first so it wins over a coincident timeout.
                    if (rx_block_lock) begin
                        next_state_s = ST_WAIT_STABLE;
                        timer_nxt_s  = CNT_ZERO;
                        stable_nxt_s = CNT_ZERO;
                    end else if (timer_r == LOCK_LAST) begin
                        retry_nxt_s = retry_inc_s;
                        timer_nxt_s = CNT_ZERO;
                        if (retry_inc_s == RETRY_LIMIT) begin
                            next_state_s = ST_FAIL;
                        end else begin
                            next_state_s = ST_SERDES_RST;
                        end
                    end else begin
                        timer_nxt_s = timer_inc_s;
                    end
                end
                ST_WAIT_STABLE: begin
                    if (!rx_block_lock) begin
                        // Lost lock before qualifying: re-wait, no retry charged.
                        next_state_s = ST_WAIT_LOCK;
                        timer_nxt_s  = CNT_ZERO;
                        stable_nxt_s = CNT_ZERO;
                    end else if (!rx_high_ber && rx_status) begin
                        if (stable_inc_s == STABLE_DONE) begin
                            next_state_s = ST_LINK_UP;
                            stable_nxt_s = CNT_ZERO;
                            retry_nxt_s  = 4'd0;
                        end else begin
                            stable_nxt_s = stable_inc_s;
                        end
                    end else begin
                        stable_nxt_s = CNT_ZERO;
                    end
                end
                ST_LINK_UP: begin
                    if (!rx_block_lock) begin
                        loss_inc_s   = 1'b1;
                        next_state_s = ST_SERDES_RST;
                        timer_nxt_s  = CNT_ZERO;
                    end else if (rx_high_ber) begin
                        next_state_s = ST_WAIT_STABLE;
                        stable_nxt_s = CNT_ZERO;
                    end else if (cfg_prbs_req) begin
                        next_state_s = ST_PRBS_TEST;
                        prbs_clr_s   = 1'b1;
                    end else begin
                        next_state_s = ST_LINK_UP;
                    end
                end
                ST_PRBS_TEST: begin
                    // Leaving test mode requalifies data mode from scratch.
                    if (!cfg_prbs_req) begin
                        next_state_s = ST_WAIT_STABLE;
                        stable_nxt_s = CNT_ZERO;
                    end else begin
                        next_state_s = ST_PRBS_TEST;
                    end
                end
                ST_FAIL: begin
                    next_state_s = ST_FAIL;
                end
                default: begin
                    next_state_s = ST_IDLE;
                    timer_nxt_s  = CNT_ZERO;
                    stable_nxt_s = CNT_ZERO;
                    retry_nxt_s  = 4'd0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the next state so they align with state_r.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            serdes_req_r <= 1'b0;
            tx_prbs_r    <= 1'b0;
            rx_prbs_r    <= 1'b0;
            link_up_r    <= 1'b0;
            link_fail_r  <= 1'b0;
        end else begin
            serdes_req_r <= (next_state_s == ST_SERDES_RST);
            tx_prbs_r    <= (next_state_s == ST_PRBS_TEST);
            rx_prbs_r    <= (next_state_s == ST_PRBS_TEST);
            link_up_r    <= (next_state_s == ST_LINK_UP);
            link_fail_r  <= (next_state_s == ST_FAIL);
        end
    end

    eth_phy_10g_sat_accum #(
        .W    (LOSS_CNT_W),
        .IN_W (1)
    ) u_lock_loss (
        .clk   (rx_clk),
        .rst_n (rx_rst_n),
        .clr   (1'b0),
        .en    (loss_inc_s),
        .add   (1'b1),
        .sum   (lock_loss_count)
    );

    eth_phy_10g_sat_accum #(
        .W    (PRBS_ERR_WIDTH),
        .IN_W (ERR_CNT_W)
    ) u_prbs_err (
        .clk   (rx_clk),
        .rst_n (rx_rst_n),
        .clr   (prbs_clr_s),
        .en    (prbs_acc_en_s),
        .add   (rx_error_count),
        .sum   (prbs_err_total)
    );

    assign serdes_rx_reset_req  = serdes_req_r;
    assign cfg_tx_prbs31_enable = tx_prbs_r;
    assign cfg_rx_prbs31_enable = rx_prbs_r;
    assign link_up              = link_up_r;
    assign link_fail            = link_fail_r;
    assign link_state           = state_r;
    assign retry_count          = retry_r;

endmodule

// File: tb/tb_eth_phy_10g_link_seq.sv
// tb_eth_phy_10g_link_seq
// Table-driven bench for the link sequencer with small timing parameters
// (SERDES_RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=16, MAX_RETRIES=3).
// Each table row drives inputs for a number of cycles; its expected output
// vector is queued on drive and popped/compared after the last edge.
// A second instance with an 8-bit PRBS accumulator shares the stimulus, and a
// stand-alone 8-bit accumulator exercises lock-loss style +1 saturation.
module tb_eth_phy_10g_link_seq;

    logic clk_tb    = 1'b0;
    logic rx_rst_tb = 1'b1;
    always #5 clk_tb = ~clk_tb;

    logic       cfg_enable, cfg_prbs_req, rx_block_lock, rx_high_ber, rx_status;
    logic [6:0] rx_error_count;

    logic        serdes_rx_reset_req, tx_prbs, rx_prbs, link_up, link_fail;
    logic [2:0]  link_state;
    logic [3:0]  retry_count;
    logic [15:0] lock_loss_count, prbs_err_total;

    logic        d8_req, d8_tx, d8_rx, d8_up, d8_fail;
    logic [2:0]  d8_state;
    logic [3:0]  d8_retry;
    logic [15:0] d8_loss;
    logic [7:0]  d8_prbs;

    logic       acc_clr, acc_en;
    logic [7:0] acc_sum;

    eth_phy_10g_link_seq #(
        .SERDES_RST_CYCLES(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(16),
        .MAX_RETRIES(3), .PRBS_ERR_WIDTH(16)
    ) dut (
        .rx_clk(clk_tb), .rx_rst_n(rx_rst_tb), .cfg_enable(cfg_enable),
        .cfg_prbs_req(cfg_prbs_req), .rx_block_lock(rx_block_lock),
        .rx_high_ber(rx_high_ber), .rx_status(rx_status),
        .rx_error_count(rx_error_count), .serdes_rx_reset_req(serdes_rx_reset_req),
        .cfg_tx_prbs31_enable(tx_prbs), .cfg_rx_prbs31_enable(rx_prbs),
        .link_up(link_up), .link_fail(link_fail), .link_state(link_state),
        .retry_count(retry_count), .lock_loss_count(lock_loss_count),
        .prbs_err_total(prbs_err_total)
    );

    eth_phy_10g_link_seq #(
        .SERDES_RST_CYCLES(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(16),
        .MAX_RETRIES(3), .PRBS_ERR_WIDTH(8)
    ) dut8 (
        .rx_clk(clk_tb), .rx_rst_n(rx_rst_tb), .cfg_enable(cfg_enable),
        .cfg_prbs_req(cfg_prbs_req), .rx_block_lock(rx_block_lock),
        .rx_high_ber(rx_high_ber), .rx_status(rx_status),
        .rx_error_count(rx_error_count), .serdes_rx_reset_req(d8_req),
        .cfg_tx_prbs31_enable(d8_tx), .cfg_rx_prbs31_enable(d8_rx),
        .link_up(d8_up), .link_fail(d8_fail), .link_state(d8_state),
        .retry_count(d8_retry), .lock_loss_count(d8_loss),
        .prbs_err_total(d8_prbs)
    );

    eth_phy_10g_sat_accum #(.W(8), .IN_W(1)) acc8 (
        .clk(clk_tb), .rst_n(rx_rst_tb), .clr(acc_clr), .en(acc_en),
        .add(1'b1), .sum(acc_sum)
    );

    // {state, req, tx, rx, up, fail, retry, loss, prbs}
    logic [43:0] obs_s;
    logic [35:0] d8_obs_s;
    assign obs_s    = {link_state, serdes_rx_reset_req, tx_prbs, rx_prbs, link_up,
                       link_fail, retry_count, lock_loss_count, prbs_err_total};
    assign d8_obs_s = {d8_state, d8_req, d8_tx, d8_rx, d8_up, d8_fail,
                       d8_retry, d8_loss, d8_prbs};

    typedef struct {
        logic       en, prbs, lock, ber, stat;
        logic [6:0] err;
        int         reps;
        logic [43:0] exp_v;
    } vec_t;

    localparam int F_NONE = 0, F_FAIL = 1, F_UP = 2, F_PRBS = 12, F_REQ = 16;

    vec_t        tbl[$];
    logic [43:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic vec_t mk(input int en, input int prbs, input int lock,
                                input int ber, input int stat, input int err,
                                input int reps, input int st, input int flags,
                                input int retry, input int loss, input int tot);
        vec_t v;
        v.en    = 1'(en);
        v.prbs  = 1'(prbs);
        v.lock  = 1'(lock);
        v.ber   = 1'(ber);
        v.stat  = 1'(stat);
        v.err   = 7'(err);
        v.reps  = reps;
        v.exp_v = {3'(st), 5'(flags), 4'(retry), 16'(loss), 16'(tot)};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [43:0] e;
        cfg_enable = 1'b0; cfg_prbs_req = 1'b0; rx_block_lock = 1'b0;
        rx_high_ber = 1'b0; rx_status = 1'b0; rx_error_count = 7'd0;
        acc_clr = 1'b0; acc_en = 1'b0;
        #2 rx_rst_tb = 1'b0;
        repeat (3) @(posedge clk_tb);
        #1 rx_rst_tb = 1'b1;
        chk("reset_state", 64'(obs_s), 64'd0);
        chk("reset_state_w8", 64'(d8_obs_s), 64'd0);

        //                en pr lk br st err reps  st flags   rt loss tot
        // normal bring-up
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   1, F_REQ,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  3,   1, F_REQ,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   2, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  9,   2, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 15,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   4, F_UP,   0, 0, 0));
        // qualifier drops in WAIT_STABLE
        tbl.push_back(mk(1, 0, 1, 1, 1, 0,  1,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 10,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0,  1,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 15,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   4, F_UP,   0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0,  1,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  5,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  1,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 15,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   4, F_UP,   0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0,  1,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   2, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 15,   3, F_NONE, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   4, F_UP,   0, 0, 0));
        // lock loss in LINK_UP and recovery; lock loss beats BER and PRBS
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   1, F_REQ,  0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  3,   1, F_REQ,  0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   2, F_NONE, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   3, F_NONE, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 16,   4, F_UP,   0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 0,  1,   1, F_REQ,  0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  4,   2, F_NONE, 0, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   3, F_NONE, 0, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 16,   4, F_UP,   0, 2, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0,  1,   3, F_NONE, 0, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 16,   4, F_UP,   0, 2, 0));
        // PRBS session: lock/BER ignored, 20 x 5 errors, release requalifies
        tbl.push_back(mk(1, 1, 1, 0, 1, 0,  1,   5, F_PRBS, 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 5, 10,   5, F_PRBS, 0, 2, 50));
        tbl.push_back(mk(1, 1, 1, 0, 1, 5, 10,   5, F_PRBS, 0, 2, 100));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   3, F_NONE, 0, 2, 100));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 15,   3, F_NONE, 0, 2, 100));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   4, F_UP,   0, 2, 100));
        // disable, then lock never asserts: three timeouts -> FAIL
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,  1,   0, F_NONE, 0, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   1, F_REQ,  0, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  4,   2, F_NONE, 0, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 63,   2, F_NONE, 0, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   1, F_REQ,  1, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  3,   1, F_REQ,  1, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   2, F_NONE, 1, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 64,   1, F_REQ,  2, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  4,   2, F_NONE, 2, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 63,   2, F_NONE, 2, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   6, F_FAIL, 3, 2, 100));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 10,   6, F_FAIL, 3, 2, 100));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0,  1,   0, F_NONE, 0, 2, 100));
        // lock arriving on the timeout cycle wins, then PRBS 3 x 127
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  1,   1, F_REQ,  0, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0,  4,   2, F_NONE, 0, 2, 100));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 63,   2, F_NONE, 0, 2, 100));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   3, F_NONE, 0, 2, 100));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 15,   3, F_NONE, 0, 2, 100));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0,  1,   4, F_UP,   0, 2, 100));
        tbl.push_back(mk(1, 1, 1, 0, 1, 0,  1,   5, F_PRBS, 0, 2, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 127, 3,  5, F_PRBS, 0, 2, 381));

        foreach (tbl[i]) begin
            cfg_enable     = tbl[i].en;
            cfg_prbs_req   = tbl[i].prbs;
            rx_block_lock  = tbl[i].lock;
            rx_high_ber    = tbl[i].ber;
            rx_status      = tbl[i].stat;
            rx_error_count = tbl[i].err;
            exp_q.push_back(tbl[i].exp_v);
            repeat (tbl[i].reps) @(posedge clk_tb);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("row%0d", i), 64'(obs_s), 64'(e));
        end

        // 8-bit PRBS accumulator clamps at 255 after 3 x 127
        chk("prbs_sat_w8", 64'(d8_prbs), 64'd255);
        chk("state_w8", 64'(d8_state), 64'd5);

        // asynchronous reset mid-PRBS, checked before any further clock edge
        #2 rx_rst_tb = 1'b0;
        #1;
        chk("async_rst", 64'(obs_s), 64'd0);
        chk("async_rst_w8", 64'(d8_obs_s), 64'd0);

        cfg_enable = 1'b0; cfg_prbs_req = 1'b0; rx_error_count = 7'd0;
        @(posedge clk_tb);
        #1 rx_rst_tb = 1'b1;

        // +1 saturating accumulator: 100, then clamp at all-ones, then clear
        acc_en = 1'b1;
        repeat (100) @(posedge clk_tb);
        #1;
        chk("acc_count_100", 64'(acc_sum), 64'd100);
        repeat (200) @(posedge clk_tb);
        #1;
        chk("acc_saturate", 64'(acc_sum), 64'd255);
        acc_en = 1'b0; acc_clr = 1'b1;
        @(posedge clk_tb);
        #1;
        chk("acc_clear", 64'(acc_sum), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
